clm_rand_sequencer: RTL and testbench

Front-end sequencer directly upstream of the CLM AES core. It accepts plaintext, key and prime-selector requests over a valid/ready handshake and fills the core's 23-entry randomness vector from an internal LFSR. It launches the core with a single-cycle `drdy_i` pulse, keeps refreshing the S-box randomness while the core runs, and captures the ciphertext into a one-entry output buffer with its own valid/ready handshake.

---
 rtl/clm_rand_sequencer_pkg.sv | 28 ++
 rtl/clm_rand_sequencer_if.sv | 23 ++
 rtl/clm_rand_sequencer_lfsr_multistep.sv | 39 +++
 rtl/clm_rand_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_clm_rand_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clm_rand_sequencer_pkg.sv
// Shared types, constants and LFSR step helper for the CLM randomness sequencer.
package types;

  localparam int unsigned RED_D              = 4;
  localparam int unsigned P_DET_W            = 3;
  localparam int unsigned RAND_ENTRIES       = 23;
  localparam int unsigned RAND_FREEZE_CYCLES = 3;
  localparam int unsigned RAND_REFRESH_FIRST = 16;
  localparam int unsigned LFSR_W             = 64;

  // Right-shift Galois mask for x^64 + x^63 + x^61 + x^60 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef logic [RED_D-1:0]   red_poly_t;
  typedef logic [P_DET_W-1:0] p_det_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    LAUNCH = 2'd2,
    RUN    = 2'd3
  } rand_seq_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/clm_rand_sequencer_if.sv
// Request (plaintext/key/p_det) and response (ciphertext) handshakes of the sequencer.
interface clm_rand_sequencer_if;
  import types::*;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_plaintext;
  logic [127:0] in_key;
  p_det_t       in_p_det;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ciphertext;

  modport slave (
    input  in_valid, in_plaintext, in_key, in_p_det, out_ready,
    output in_ready, out_valid, out_ciphertext
  );

  modport master (
    output in_valid, in_plaintext, in_key, in_p_det, out_ready,
    input  in_ready, out_valid, out_ciphertext
  );
endinterface

// File: rtl/clm_rand_sequencer_lfsr_multistep.sv
// 64-bit Galois LFSR advancing d steps per adv; a zero seed falls back to SEED.
module lfsr_multistep
  import types::*;
#(
  parameter int unsigned        d    = RED_D,
  parameter logic [LFSR_W-1:0]  SEED = 64'hACE1_0F0F_1234_5678
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic [d-1:0]      out
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_stepped;

  always_comb begin
    w_stepped = r_state;
    for (int unsigned i = 0; i < d; i++) begin
      w_stepped = lfsr_step(w_stepped);
    end
  end

  // Load wins over advance so a request accepted alongside a seed load uses the new seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (load) begin
      r_state <= (seed == '0) ? SEED : seed;
    end else if (adv) begin
      r_state <= w_stepped;
    end
  end

  assign out = r_state[d-1:0];

endmodule

// File: rtl/clm_rand_sequencer.sv
// Front-end sequencer for the CLM AES core: fills the randomness vector, launches the core,
// buffers the ciphertext. CLM_RAND_REFRESH_EN enables S-box randomness refresh during RUN.
module clm_rand_sequencer
  import types::*;
#(
  parameter int unsigned       d       = RED_D,
  parameter logic [LFSR_W-1:0] SEED    = 64'hACE1_0F0F_1234_5678,
  parameter int unsigned       TIMEOUT = 1023
) (
  input  logic                              clk,
  input  logic                              rst,
  clm_rand_sequencer_if.slave               bus,
  input  logic                              seed_load,
  input  logic [LFSR_W-1:0]                 seed,
  output logic                              core_drdy_i,
  input  logic                              core_drdy_o,
  output logic [127:0]                      core_plaintext,
  output logic [127:0]                      core_key,
  output p_det_t                            core_p_det,
  output red_poly_t [0:RAND_ENTRIES-1]      core_random_vect,
  input  logic [127:0]                      core_ciphertext,
  output logic                              err
);

  localparam int unsigned IDX_W = $clog2(RAND_ENTRIES);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  rand_seq_state_t              r_state;
  rand_seq_state_t              w_next;
  logic [IDX_W-1:0]             r_fill_idx;
  logic [CNT_W-1:0]             r_run_cnt;
  logic                         r_drdy;
  logic [127:0]                 r_plaintext;
  logic [127:0]                 r_key;
  p_det_t                       r_p_det;
  red_poly_t [0:RAND_ENTRIES-1] r_vect;
  logic                         r_out_valid;
  logic [127:0]                 r_out_ct;
  logic                         r_err;

  logic         w_in_ready;
  logic         w_accept;
  logic         w_fill;
  logic         w_refresh;
  logic         w_capture;
  logic         w_timeout;
  logic         w_lfsr_load;
  logic [d-1:0] w_lfsr_out;

  assign w_in_ready  = (r_state == IDLE) && !r_out_valid;
  assign w_lfsr_load = seed_load && (r_state == IDLE);

  lfsr_multistep #(
    .d    (d),
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (w_lfsr_load),
    .seed (seed),
    .adv  (w_fill || w_refresh),
    .out  (w_lfsr_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_fill    = 1'b0;
    w_refresh = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid && w_in_ready) begin
          w_accept = 1'b1;
          w_next   = FILL;
        end
      end
      FILL: begin
        w_fill = 1'b1;
        if (r_fill_idx == IDX_W'(RAND_ENTRIES - 1)) begin
          w_next = LAUNCH;
        end
      end
      LAUNCH: begin
        w_next = RUN;
      end
      RUN: begin
`ifdef CLM_RAND_REFRESH_EN
        // Hold S-box randomness during parameter calculation and data preparation.
        w_refresh = (r_run_cnt >= CNT_W'(RAND_FREEZE_CYCLES));
`endif
        if (core_drdy_o) begin
          w_capture = 1'b1;
          w_next    = IDLE;
        end else if (r_run_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

`ifdef CLM_RAND_REFRESH_EN
  logic [IDX_W-1:0] r_ref_idx;

  // Round-robin pointer over entries 16..22, restarted at every launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_idx <= IDX_W'(RAND_REFRESH_FIRST);
    end else if (r_state == LAUNCH) begin
      r_ref_idx <= IDX_W'(RAND_REFRESH_FIRST);
    end else if (w_refresh) begin
      r_ref_idx <= (r_ref_idx == IDX_W'(RAND_ENTRIES - 1)) ? IDX_W'(RAND_REFRESH_FIRST)
                                                           : r_ref_idx + IDX_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_idx  <= '0;
      r_run_cnt   <= '0;
      r_drdy      <= 1'b0;
      r_plaintext <= '0;
      r_key       <= '0;
      r_p_det     <= '0;
      r_vect      <= '0;
      r_out_valid <= 1'b0;
      r_out_ct    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_drdy <= (w_next == LAUNCH);
      if (w_accept) begin
        r_plaintext <= bus.in_plaintext;
        r_key       <= bus.in_key;
        r_p_det     <= bus.in_p_det;
        r_fill_idx  <= '0;
      end
      if (w_fill) begin
        r_vect[r_fill_idx] <= red_poly_t'(w_lfsr_out);
        r_fill_idx         <= r_fill_idx + IDX_W'(1);
      end
`ifdef CLM_RAND_REFRESH_EN
      if (w_refresh) begin
        r_vect[r_ref_idx] <= red_poly_t'(w_lfsr_out);
      end
`endif
      if (r_state == LAUNCH) begin
        r_run_cnt <= '0;
      end else if (r_state == RUN) begin
        r_run_cnt <= r_run_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_out_ct    <= core_ciphertext;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_ciphertext = r_out_ct;
  assign core_drdy_i        = r_drdy;
  assign core_plaintext     = r_plaintext;
  assign core_key           = r_key;
  assign core_p_det         = r_p_det;
  assign core_random_vect   = r_vect;
  assign err                = r_err;

endmodule

// File: tb/tb_clm_rand_sequencer.sv
// Directed/random bench for clm_rand_sequencer against a polynomial-level LFSR and vector model.
module tb_clm_rand_sequencer;
  import types::*;

  localparam logic [63:0]  SEED    = 64'hACE1_0F0F_1234_5678;
  localparam int           TIMEOUT = 1023;
  localparam logic [64:0]  POLY    = 65'h1_B000_0000_0000_0001;
  localparam logic [127:0] AES_CT  = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
`ifdef CLM_RAND_REFRESH_EN
  localparam bit REFRESH = 1'b1;
`else
  localparam bit REFRESH = 1'b0;
`endif

  logic                         clk;
  logic                         rst;
  logic                         seed_load;
  logic [63:0]                  seed;
  logic                         core_drdy_i;
  logic                         core_drdy_o;
  logic [127:0]                 core_plaintext;
  logic [127:0]                 core_key;
  p_det_t                       core_p_det;
  red_poly_t [0:RAND_ENTRIES-1] core_random_vect;
  logic [127:0]                 core_ciphertext;
  logic                         err;

  clm_rand_sequencer_if bus ();

  clm_rand_sequencer #(
    .d       (4),
    .SEED    (SEED),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .seed_load        (seed_load),
    .seed             (seed),
    .core_drdy_i      (core_drdy_i),
    .core_drdy_o      (core_drdy_o),
    .core_plaintext   (core_plaintext),
    .core_key         (core_key),
    .core_p_det       (core_p_det),
    .core_random_vect (core_random_vect),
    .core_ciphertext  (core_ciphertext),
    .err              (err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int drdy_pulses = 0;

  logic [63:0]                  m_lfsr;
  red_poly_t [0:RAND_ENTRIES-1] m_vect;

  always #5 clk = ~clk;

  always @(posedge clk) if (core_drdy_i === 1'b1) drdy_pulses++;

  // LFSR as repeated division by x modulo the feedback polynomial
  function automatic logic [63:0] ref_adv(input logic [63:0] s, input int n);
    logic [64:0] t;
    for (int i = 0; i < n; i++) begin
      t = {1'b0, s};
      if (s[0]) t = t ^ POLY;
      s = t[64:1];
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept a request, check launch timing and the filled vector; returns in RUN cycle 0.
  task automatic request(input logic [127:0] pt, input logic [127:0] key, input p_det_t pd,
                         input bit load_at_accept, input logic [63:0] acc_seed,
                         input bit load_in_fill);
    int cyc;
    bit seen;
    bus.in_plaintext = pt;
    bus.in_key       = key;
    bus.in_p_det     = pd;
    bus.in_valid     = 1'b1;
    if (load_at_accept) begin
      seed_load = 1'b1;
      seed      = acc_seed;
      m_lfsr    = (acc_seed == 64'd0) ? SEED : acc_seed;
    end
    chk("in_ready_at_accept", 128'(bus.in_ready), 128'd1);
    for (int i = 0; i < RAND_ENTRIES; i++) begin
      m_vect[i] = m_lfsr[3:0];
      m_lfsr    = ref_adv(m_lfsr, 4);
    end
    tick();
    bus.in_valid = 1'b0;
    seed_load    = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (load_in_fill) begin
        seed_load = 1'b1;
        seed      = {$urandom, $urandom};
      end
      if (core_drdy_i === 1'b1) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    seed_load = 1'b0;
    chk("drdy_cycle", 128'(cyc), 128'd24);
    chk("vect_after_fill", 128'(core_random_vect), 128'(m_vect));
    chk("core_plaintext", core_plaintext, pt);
    chk("core_key", core_key, key);
    chk("core_p_det", 128'(core_p_det), 128'(pd));
    tick();
    chk("drdy_single_pulse", 128'(core_drdy_i), 128'd0);
  endtask

  // Model RUN; resp_k < 0 means the core never answers.
  task automatic run_core(input int resp_k, input logic [127:0] ct);
    for (int k = 0; k < TIMEOUT; k++) begin
      if (k < 60) chk("vect_run", 128'(core_random_vect), 128'(m_vect));
      if (k == resp_k) begin
        core_drdy_o     = 1'b1;
        core_ciphertext = ct;
      end else begin
        core_ciphertext = rnd128();
      end
      if (resp_k < 0 && k == TIMEOUT - 1) chk("err_before_timeout", 128'(err), 128'd0);
      if (REFRESH && k >= RAND_FREEZE_CYCLES) begin
        m_vect[RAND_REFRESH_FIRST + (k - RAND_FREEZE_CYCLES) % 7] = m_lfsr[3:0];
        m_lfsr = ref_adv(m_lfsr, 4);
      end
      tick();
      if (k == resp_k) begin
        core_drdy_o = 1'b0;
        break;
      end
    end
  endtask

  // Check the buffered result, hold it back for a while, then drain.
  task automatic drain(input logic [127:0] pt, input logic [127:0] ct, input int hold);
    chk("out_valid_set", 128'(bus.out_valid), 128'd1);
    chk("out_ciphertext", bus.out_ciphertext, ct);
    bus.in_valid     = 1'b1;
    bus.in_plaintext = rnd128();
    for (int i = 0; i < hold; i++) begin
      chk("in_ready_blocked", 128'(bus.in_ready), 128'd0);
      tick();
    end
    chk("out_valid_held", 128'(bus.out_valid), 128'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("out_valid_drained", 128'(bus.out_valid), 128'd0);
    chk("in_ready_after_drain", 128'(bus.in_ready), 128'd1);
    chk("plaintext_stable", core_plaintext, pt);
  endtask

  initial begin
    logic [127:0] pt;
    logic [127:0] ct;
    int p0;
    clk = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_plaintext = '0;
    bus.in_key = '0;
    bus.in_p_det = '0;
    bus.out_ready = 1'b0;
    seed_load = 1'b0;
    seed = '0;
    core_drdy_o = 1'b0;
    core_ciphertext = '0;
    m_lfsr = SEED;
    m_vect = '0;
    repeat (3) tick();

    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_ct", bus.out_ciphertext, 128'd0);
    chk("rst_drdy", 128'(core_drdy_i), 128'd0);
    chk("rst_vect", 128'(core_random_vect), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    rst = 1'b0;
    tick();

    // core_drdy_o while idle must not fill the buffer
    core_drdy_o = 1'b1;
    core_ciphertext = rnd128();
    tick();
    core_drdy_o = 1'b0;
    chk("idle_drdy_o_ignored", 128'(bus.out_valid), 128'd0);

    // Zero key/plaintext from the default seed, AES response after 50 cycles
    p0 = drdy_pulses;
    request('0, '0, p_det_t'($urandom), 1'b0, '0, 1'b0);
    run_core(49, AES_CT);
    chk("drdy_pulse_count", 128'(drdy_pulses - p0), 128'd1);
    drain('0, AES_CT, 4);

    // Core never answers
    pt = rnd128();
    p0 = drdy_pulses;
    request(pt, rnd128(), p_det_t'($urandom), 1'b0, '0, 1'b0);
    run_core(-1, '0);
    chk("err_after_timeout", 128'(err), 128'd1);
    chk("timeout_in_ready", 128'(bus.in_ready), 128'd1);
    chk("timeout_out_valid", 128'(bus.out_valid), 128'd0);
    chk("timeout_pulses", 128'(drdy_pulses - p0), 128'd1);

    pt = rnd128();
    ct = rnd128();
    request(pt, rnd128(), p_det_t'($urandom), 1'b0, '0, 1'b0);
    run_core(int'($urandom_range(40, 5)), ct);
    drain(pt, ct, 2);
    chk("err_sticky", 128'(err), 128'd1);

    // Zero seed load falls back to SEED; loads during FILL are ignored
    seed_load = 1'b1;
    seed = '0;
    tick();
    seed_load = 1'b0;
    m_lfsr = SEED;
    pt = rnd128();
    ct = rnd128();
    request(pt, rnd128(), p_det_t'($urandom), 1'b0, '0, 1'b1);
    run_core(int'($urandom_range(30, 0)), ct);
    drain(pt, ct, 1);

    // Seed load coinciding with accept feeds the first FILL step
    pt = rnd128();
    ct = rnd128();
    request(pt, rnd128(), p_det_t'($urandom), 1'b1, {$urandom, $urandom} | 64'd1, 1'b0);
    run_core(int'($urandom_range(25, 2)), ct);
    drain(pt, ct, 0);

    // Reset in FILL cycle 10
    bus.in_plaintext = rnd128();
    bus.in_key = rnd128();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("midrst_vect", 128'(core_random_vect), 128'd0);
    chk("midrst_plaintext", core_plaintext, 128'd0);
    chk("midrst_key", core_key, 128'd0);
    chk("midrst_err", 128'(err), 128'd0);
    chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    tick();
    tick();
    rst = 1'b0;
    p0 = drdy_pulses;
    repeat (100) tick();
    chk("no_drdy_after_rst", 128'(drdy_pulses - p0), 128'd0);

    // LFSR must be back at SEED
    m_lfsr = SEED;
    pt = rnd128();
    ct = rnd128();
    request(pt, rnd128(), p_det_t'($urandom), 1'b0, '0, 1'b0);
    run_core(10, ct);
    drain(pt, ct, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
